// File: rtl/hand_tracker.sv
// hand_tracker: per-frame centroids and grab flags for two colour markers, with a fixed-latency
// sequential divider. Define HAND_SMOOTH_EN to average each new centroid with the previous position.
module hand_tracker #(
   parameter int H_ACTIVE = 1024,
   parameter int V_ACTIVE = 768,
   parameter int MIN_PIX  = 16,
   parameter int GRAB_HI  = 600,
   parameter int GRAB_LO  = 300,
   parameter int SUM_W    = 30,
   parameter int CNT_W    = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        vsync,
   input  logic        pix_valid,
   input  logic        hand1_hit,
   input  logic        hand2_hit,
   output logic [10:0] hand1x,
   output logic [9:0]  hand1y,
   output logic [10:0] hand2x,
   output logic [9:0]  hand2y,
   output logic        grab1,
   output logic        grab2,
   output logic        update,
   output logic        overrun
);

   localparam int                STEP_W    = $clog2(SUM_W);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SUM_W - 1);
   localparam logic [11:0]       H_LIM     = 12'(H_ACTIVE);
   localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);
   localparam logic [SUM_W-1:0]  X_MAX     = SUM_W'(H_ACTIVE - 1);
   localparam logic [SUM_W-1:0]  Y_MAX     = SUM_W'(V_ACTIVE - 1);
   localparam logic [10:0]       X_MAX_P   = 11'(H_ACTIVE - 1);
   localparam logic [9:0]        Y_MAX_P   = 10'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  MIN_PIX_C = CNT_W'(MIN_PIX);
   localparam logic [CNT_W-1:0]  GRAB_HI_C = CNT_W'(GRAB_HI);
   localparam logic [CNT_W-1:0]  GRAB_LO_C = CNT_W'(GRAB_LO);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[SUM_W]) return '1;
      else return s[SUM_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == '1) return c;
      else return c + CNT_W'(1);
   endfunction

   function automatic logic [10:0] clamp_x(input logic [SUM_W-1:0] q);
      if (q > X_MAX) return X_MAX_P;
      else return q[10:0];
   endfunction

   function automatic logic [9:0] clamp_y(input logic [SUM_W-1:0] q);
      if (q > Y_MAX) return Y_MAX_P;
      else return q[9:0];
   endfunction

   function automatic logic next_grab(input logic [CNT_W-1:0] cnt, input logic old);
      if (cnt < MIN_PIX_C) return 1'b0;
      else if (cnt >= GRAB_HI_C) return 1'b1;
      else if (cnt < GRAB_LO_C) return 1'b0;
      else return old;
   endfunction

`ifdef HAND_SMOOTH_EN
   function automatic logic [10:0] avg_x(input logic [10:0] a, input logic [10:0] b);
      return 11'(({1'b0, a} + {1'b0, b}) >> 1);
   endfunction

   function automatic logic [9:0] avg_y(input logic [9:0] a, input logic [9:0] b);
      return 10'(({1'b0, a} + {1'b0, b}) >> 1);
   endfunction
`endif

   state_t             state_r, state_nxt_s;
   logic               vsync_d_r;
   logic               edge_s, pix_ok_s, last_s;
   logic [1:0]         hit_s;
   logic [SUM_W-1:0]   acc_sx_r [2];
   logic [SUM_W-1:0]   acc_sy_r [2];
   logic [CNT_W-1:0]   acc_cnt_r [2];
   logic [SUM_W-1:0]   snap_sx_r [2];
   logic [SUM_W-1:0]   snap_sy_r [2];
   logic [CNT_W-1:0]   snap_cnt_r [2];
   logic [SUM_W-1:0]   q_r, q_nxt_s, next_dividend_s;
   logic [CNT_W-1:0]   rem_r, rem_nxt_s, divisor_s;
   logic [CNT_W:0]     shifted_s;
   logic               ge_s;
   logic [STEP_W-1:0]  step_r;
   logic [1:0]         op_r;
   logic [SUM_W-1:0]   res_x1_r, res_y1_r, res_x2_r;
   logic [10:0]        cx1_s, cx2_s, new1x_s, new2x_s;
   logic [9:0]         cy1_s, cy2_s, new1y_s, new2y_s;

   assign edge_s   = vsync & ~vsync_d_r;
   assign pix_ok_s = pix_valid && ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);
   assign hit_s    = {hand2_hit, hand1_hit} & {2{pix_ok_s}};
   assign last_s   = (state_r == ST_DIV) && (op_r == 2'd3) && (step_r == STEP_LAST);

   // vsync delay for edge detection; kept running through reset so no false edge follows it
   always_ff @(posedge clk) begin
      vsync_d_r <= vsync;
   end

   // Per-frame accumulators; a hit on the edge cycle seeds the new frame
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            acc_sx_r[i]  <= '0;
            acc_sy_r[i]  <= '0;
            acc_cnt_r[i] <= '0;
         end else if (edge_s) begin
            acc_sx_r[i]  <= hit_s[i] ? SUM_W'(hcount) : '0;
            acc_sy_r[i]  <= hit_s[i] ? SUM_W'(vcount) : '0;
            acc_cnt_r[i] <= hit_s[i] ? CNT_W'(1) : '0;
         end else if (hit_s[i]) begin
            acc_sx_r[i]  <= sat_add(acc_sx_r[i], SUM_W'(hcount));
            acc_sy_r[i]  <= sat_add(acc_sy_r[i], SUM_W'(vcount));
            acc_cnt_r[i] <= sat_inc(acc_cnt_r[i]);
         end
      end
   end

   // Snapshot of the finished frame, taken only when the divider is free
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            snap_sx_r[i]  <= '0;
            snap_sy_r[i]  <= '0;
            snap_cnt_r[i] <= '0;
         end else if (edge_s && (state_r == ST_IDLE)) begin
            snap_sx_r[i]  <= acc_sx_r[i];
            snap_sy_r[i]  <= acc_sy_r[i];
            snap_cnt_r[i] <= acc_cnt_r[i];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else state_r <= state_nxt_s;
   end

   // FSM next state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) state_nxt_s = ST_LOAD;
            else state_nxt_s = ST_IDLE;
         end
         ST_LOAD: state_nxt_s = ST_DIV;
         ST_DIV: begin
            if (last_s) state_nxt_s = ST_DONE;
            else state_nxt_s = ST_DIV;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Restoring divider step: dividend bits shift out of q_r while quotient bits shift in.
   // A zero divisor yields all-ones, which is harmless because such hands are ignored.
   always_comb begin
      divisor_s = snap_cnt_r[op_r[1]];
      shifted_s = {rem_r, q_r[SUM_W-1]};
      ge_s      = (shifted_s >= {1'b0, divisor_s});
      q_nxt_s   = {q_r[SUM_W-2:0], ge_s};
      if (ge_s) rem_nxt_s = CNT_W'(shifted_s - {1'b0, divisor_s});
      else rem_nxt_s = shifted_s[CNT_W-1:0];
      case (op_r)
         2'd0:    next_dividend_s = snap_sy_r[0];
         2'd1:    next_dividend_s = snap_sx_r[1];
         2'd2:    next_dividend_s = snap_sy_r[1];
         default: next_dividend_s = snap_sx_r[0];
      endcase
   end

   // Divider sequencing over h1x, h1y, h2x, h2y
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r      <= '0;
         rem_r    <= '0;
         step_r   <= '0;
         op_r     <= 2'd0;
         res_x1_r <= '0;
         res_y1_r <= '0;
         res_x2_r <= '0;
      end else begin
         case (state_r)
            ST_LOAD: begin
               q_r    <= snap_sx_r[0];
               rem_r  <= '0;
               step_r <= '0;
               op_r   <= 2'd0;
            end
            ST_DIV: begin
               if (step_r == STEP_LAST) begin
                  case (op_r)
                     2'd0:    res_x1_r <= q_nxt_s;
                     2'd1:    res_y1_r <= q_nxt_s;
                     2'd2:    res_x2_r <= q_nxt_s;
                     default: begin end
                  endcase
                  q_r    <= next_dividend_s;
                  rem_r  <= '0;
                  step_r <= '0;
                  op_r   <= op_r + 2'd1;
               end else begin
                  q_r    <= q_nxt_s;
                  rem_r  <= rem_nxt_s;
                  step_r <= step_r + STEP_W'(1);
               end
            end
            default: begin end
         endcase
      end
   end

   // New positions; the last quotient (h2y) is taken straight from the divider step
   always_comb begin
      cx1_s   = clamp_x(res_x1_r);
      cy1_s   = clamp_y(res_y1_r);
      cx2_s   = clamp_x(res_x2_r);
      cy2_s   = clamp_y(q_nxt_s);
      new1x_s = hand1x;
      new1y_s = hand1y;
      new2x_s = hand2x;
      new2y_s = hand2y;
      if (snap_cnt_r[0] >= MIN_PIX_C) begin
`ifdef HAND_SMOOTH_EN
         new1x_s = avg_x(hand1x, cx1_s);
         new1y_s = avg_y(hand1y, cy1_s);
`else
         new1x_s = cx1_s;
         new1y_s = cy1_s;
`endif
      end else begin
         new1x_s = hand1x;
         new1y_s = hand1y;
      end
      if (snap_cnt_r[1] >= MIN_PIX_C) begin
`ifdef HAND_SMOOTH_EN
         new2x_s = avg_x(hand2x, cx2_s);
         new2y_s = avg_y(hand2y, cy2_s);
`else
         new2x_s = cx2_s;
         new2y_s = cy2_s;
`endif
      end else begin
         new2x_s = hand2x;
         new2y_s = hand2y;
      end
   end

   // Registered outputs, loaded together with the update pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         hand1x  <= '0;
         hand1y  <= '0;
         hand2x  <= '0;
         hand2y  <= '0;
         grab1   <= 1'b0;
         grab2   <= 1'b0;
         update  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         update  <= last_s;
         overrun <= edge_s && (state_r != ST_IDLE);
         if (last_s) begin
            hand1x <= new1x_s;
            hand1y <= new1y_s;
            hand2x <= new2x_s;
            hand2y <= new2y_s;
            grab1  <= next_grab(snap_cnt_r[0], grab1);
            grab2  <= next_grab(snap_cnt_r[1], grab2);
         end
      end
   end

endmodule

// File: tb/tb_hand_tracker.sv
// Self-checking bench for hand_tracker: directed frame scenarios plus random frames,
// compared against a frame-level arithmetic model of centroids and grab hysteresis.
module tb_hand_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        vsync, pix_valid, hand1_hit, hand2_hit;
   logic [10:0] hand1x, hand2x;
   logic [9:0]  hand1y, hand2y;
   logic        grab1, grab2, update, overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int m_cnt [2];
   int m_sx  [2];
   int m_sy  [2];
   int e_x   [2];
   int e_y   [2];
   int e_g   [2];
   int seq_n [4] = '{900, 450, 250, 450};
   int seq_g [4] = '{1, 1, 0, 0};

   always #5 clk = ~clk;

   hand_tracker dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
      .pix_valid(pix_valid), .hand1_hit(hand1_hit), .hand2_hit(hand2_hit),
      .hand1x(hand1x), .hand1y(hand1y), .hand2x(hand2x), .hand2y(hand2y),
      .grab1(grab1), .grab2(grab2), .update(update), .overrun(overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_sx[i]  = 0;
         m_sy[i]  = 0;
      end
   endfunction

   function automatic void model_pix(int h, int v, bit valid, bit h1, bit h2);
      if (valid && h < 1024 && v < 768) begin
         if (h1) begin m_cnt[0]++; m_sx[0] += h; m_sy[0] += v; end
         if (h2) begin m_cnt[1]++; m_sx[1] += h; m_sy[1] += v; end
      end
   endfunction

   // Frame result: centroid = floor(sum/count), clamped; absent hands hold and lose grab.
   function automatic void model_frame();
      int cx, cy;
      for (int i = 0; i < 2; i++) begin
         if (m_cnt[i] >= 16) begin
            cx = m_sx[i] / m_cnt[i];
            cy = m_sy[i] / m_cnt[i];
            if (cx > 1023) cx = 1023;
            if (cy > 767) cy = 767;
`ifdef HAND_SMOOTH_EN
            e_x[i] = (e_x[i] + cx) / 2;
            e_y[i] = (e_y[i] + cy) / 2;
`else
            e_x[i] = cx;
            e_y[i] = cy;
`endif
            if (m_cnt[i] >= 600) e_g[i] = 1;
            else if (m_cnt[i] < 300) e_g[i] = 0;
         end else begin
            e_g[i] = 0;
         end
      end
      model_clear();
   endfunction

   function automatic void model_reset();
      model_clear();
      for (int i = 0; i < 2; i++) begin
         e_x[i] = 0; e_y[i] = 0; e_g[i] = 0;
      end
   endfunction

   task automatic pixel(input int h, input int v, input bit valid, input bit h1, input bit h2);
      @(negedge clk);
      vsync = 1'b0; hcount = 11'(h); vcount = 10'(v);
      pix_valid = valid; hand1_hit = h1; hand2_hit = h2;
      @(posedge clk);
      model_pix(h, v, valid, h1, h2);
   endtask

   task automatic idle_bus();
      @(negedge clk);
      pix_valid = 1'b0; hand1_hit = 1'b0; hand2_hit = 1'b0;
   endtask

   task automatic count_updates(input int n, output int seen);
      seen = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (update !== 1'b0) seen++;
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, " hand1x"}, 32'(hand1x), e_x[0]);
      check({tag, " hand1y"}, 32'(hand1y), e_y[0]);
      check({tag, " hand2x"}, 32'(hand2x), e_x[1]);
      check({tag, " hand2y"}, 32'(hand2y), e_y[1]);
      check({tag, " grab1"}, 32'(grab1), e_g[0]);
      check({tag, " grab2"}, 32'(grab2), e_g[1]);
      check({tag, " overrun"}, 32'(overrun), 0);
   endtask

   // vsync edge at cycle E, then expect exactly one update at E+122
   task automatic frame_end(input string tag, input bit edge_hit);
      int seen;
      @(negedge clk);
      vsync = 1'b1; hcount = 11'd500; vcount = 10'd300;
      pix_valid = edge_hit; hand1_hit = edge_hit; hand2_hit = 1'b0;
      @(posedge clk);
      model_frame();
      model_pix(500, 300, edge_hit, edge_hit, 1'b0);
      @(negedge clk);
      vsync = 1'b0; pix_valid = 1'b0; hand1_hit = 1'b0;
      count_updates(120, seen);
      check({tag, " early update"}, seen, 0);
      @(posedge clk); #1;
      check({tag, " update"}, 32'(update), 1);
      check_outs(tag);
      @(posedge clk); #1;
      check({tag, " update end"}, 32'(update), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; vsync = 1'b0; pix_valid = 1'b0; hand1_hit = 1'b0; hand2_hit = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int n;
      reset = 1'b1; vsync = 1'b0; pix_valid = 1'b0; hand1_hit = 1'b0; hand2_hit = 1'b0;
      hcount = 11'd0; vcount = 10'd0;
      repeat (3) @(posedge clk);
      do_reset();
      check_outs("reset");
      check("reset update", 32'(update), 0);

      // 10x10 block for marker 1 only
      for (int y = 200; y < 210; y++)
         for (int x = 100; x < 110; x++) pixel(x, y, 1'b1, 1'b1, 1'b0);
      frame_end("block", 1'b0);
`ifndef HAND_SMOOTH_EN
      check("block lit x", 32'(hand1x), 104);
      check("block lit y", 32'(hand1y), 204);
`endif
      check("block lit grab1", 32'(grab1), 0);
      check("block lit hand2x", 32'(hand2x), 0);

      // Grab hysteresis over 900 / 450 / 250 / 450 pixel frames
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < seq_n[s]; k++)
            pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b1, 1'b1, 1'b0);
         frame_end("grab seq", 1'b0);
         check("grab seq lit", 32'(grab1), seq_g[s]);
      end

      // Both hands grabbing, then a frame with only out-of-range or invalid hits
      for (int k = 0; k < 700; k++)
         pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b1, 1'b1, k < 650);
      frame_end("both grab", 1'b0);
      for (int k = 0; k < 40; k++) pixel(1030 + k % 5, $urandom_range(0, 767), 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 40; k++) pixel($urandom_range(0, 1023), 770 + k % 3, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 30; k++) pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b0, 1'b1, 1'b1);
      frame_end("out of range", 1'b0);

      // Hit on the edge cycle belongs to the next frame
      for (int k = 0; k < 20; k++) pixel(600 + k, 400, 1'b1, 1'b0, 1'b1);
      frame_end("edge hit a", 1'b1);
      for (int k = 0; k < 20; k++) pixel(100 + k, 100 + k, 1'b1, 1'b1, 1'b0);
      frame_end("edge hit b", 1'b0);

      // Second vsync edge at E+50 while dividing
      for (int k = 0; k < 60; k++)
         pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b1, 1'b1, k < 30);
      @(negedge clk);
      vsync = 1'b1; pix_valid = 1'b0; hand1_hit = 1'b0; hand2_hit = 1'b0;
      @(posedge clk);
      model_frame();
      for (int k = 0; k < 10; k++)
         pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b1, 1'b1, 1'b1);
      idle_bus();
      count_updates(39, seen);
      check("ovr early update", seen, 0);
      @(negedge clk); vsync = 1'b1;
      @(posedge clk); #1;
      check("ovr pulse", 32'(overrun), 1);
      model_clear();
      @(negedge clk); vsync = 1'b0;
      @(posedge clk); #1;
      check("ovr pulse end", 32'(overrun), 0);
      count_updates(69, seen);
      check("ovr mid update", seen, 0);
      @(posedge clk); #1;
      check("ovr update", 32'(update), 1);
      check_outs("ovr");
      count_updates(150, seen);
      check("ovr single update", seen, 0);

      // Reset at E+40 aborts the division
      for (int k = 0; k < 50; k++)
         pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      vsync = 1'b1; pix_valid = 1'b0; hand1_hit = 1'b0; hand2_hit = 1'b0;
      @(posedge clk);
      @(negedge clk); vsync = 1'b0;
      repeat (39) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      model_reset();
      check_outs("mid reset");
      check("mid reset update", 32'(update), 0);
      count_updates(150, seen);
      check("mid reset no update", seen, 0);
      for (int k = 0; k < 60; k++)
         pixel($urandom_range(0, 1023), $urandom_range(0, 767), 1'b1, 1'b1, 1'b1);
      frame_end("after reset", 1'b0);

      // Random frames
      repeat (5) begin
         n = $urandom_range(100, 1200);
         for (int k = 0; k < n; k++)
            pixel($urandom_range(0, 1100), $urandom_range(0, 800), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
         frame_end("random", 1'b0);
      end

`ifdef HAND_SMOOTH_EN
      // Centroid 200 from rest: 0 -> 100 -> 150
      do_reset();
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 16; k++) begin
            pixel(199, 300, 1'b1, 1'b1, 1'b0);
            pixel(201, 300, 1'b1, 1'b1, 1'b0);
         end
         frame_end("smooth", 1'b0);
         check("smooth lit x", 32'(hand1x), (f == 0) ? 100 : 150);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
